// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared types and defaults for the pipeline freeze controller
package arm_pipe_pkg;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_DONE = 2'd2
    } mem_state_e;

    localparam int MEM_WAIT_DEF = 4;
    localparam int STAT_W_DEF   = 32;

endpackage

// File: rtl/pipeline_freeze_ctrl_if.sv
// rtl/pipeline_freeze_ctrl_if.sv - stall/flush control bundle between pipeline and controller
interface pipeline_freeze_ctrl_if
    import arm_pipe_pkg::*;
#(
    parameter int STAT_W = STAT_W_DEF
);
    logic              hazard;
    logic              branch_taken;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              freeze_if;
    logic              bubble_id;
    logic              freeze_pipe;
    logic              flush;
    logic              sram_busy;
    logic [STAT_W-1:0] stat_stall;
    logic [STAT_W-1:0] stat_hazard;
    logic [STAT_W-1:0] stat_flush;

    // Pipeline side: supplies hazard/branch/memory status, consumes controls
    modport master (
        output hazard, branch_taken, mem_r_en, mem_w_en,
        input  freeze_if, bubble_id, freeze_pipe, flush, sram_busy,
        input  stat_stall, stat_hazard, stat_flush
    );

    // Controller side
    modport slave (
        input  hazard, branch_taken, mem_r_en, mem_w_en,
        output freeze_if, bubble_id, freeze_pipe, flush, sram_busy,
        output stat_stall, stat_hazard, stat_flush
    );
endinterface

// File: rtl/sram_wait_fsm.sv
// rtl/sram_wait_fsm.sv - multi-cycle SRAM access tracker producing the memory stall
module sram_wait_fsm
    import arm_pipe_pkg::*;
#(
    parameter int MEM_WAIT = MEM_WAIT_DEF,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic mem_stall,
    output logic sram_busy
);
    // IDLE consumes the first stall cycle, so WAIT only covers the remaining MEM_WAIT-1
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MEM_WAIT > 1) ? (MEM_WAIT - 2) : 0);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state and wait-counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MS_IDLE: begin
                if (req) begin
                    if (MEM_WAIT == 1) begin
                        state_d = MS_DONE;
                    end else begin
                        state_d = MS_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            MS_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = MS_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MS_DONE: state_d = MS_IDLE;
            default: state_d = MS_IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall starts in the request cycle itself; DONE lets the pipeline advance
    assign mem_stall = ((state_q == MS_IDLE) && req) || (state_q == MS_WAIT);
    assign sram_busy = (state_q != MS_IDLE);

endmodule

// File: rtl/pipeline_freeze_ctrl.sv
// rtl/pipeline_freeze_ctrl.sv - pipeline stall/flush controller; optional FREEZE_STATS_EN stats counters
module pipeline_freeze_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int MEM_WAIT = MEM_WAIT_DEF,
    parameter int CNT_W    = 4,
    parameter int STAT_W   = STAT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    pipeline_freeze_ctrl_if.slave         bus
);
    logic mem_req;
    logic mem_stall;
    logic hazard_eff;

    assign mem_req = bus.mem_r_en | bus.mem_w_en;

    sram_wait_fsm #(
        .MEM_WAIT (MEM_WAIT),
        .CNT_W    (CNT_W)
    ) u_sram_wait_fsm (
        .clk       (clk),
        .rst       (rst),
        .req       (mem_req),
        .mem_stall (mem_stall),
        .sram_busy (bus.sram_busy)
    );

    // A taken branch overrides the hazard so IF fetches the branch target
    assign hazard_eff = bus.hazard & ~bus.branch_taken;

    // Stall/flush priority: memory stall dominates, branch flush waits for DONE
    always_comb begin
        bus.freeze_pipe = mem_stall;
        bus.freeze_if   = mem_stall | hazard_eff;
        bus.bubble_id   = hazard_eff & ~mem_stall;
        bus.flush       = bus.branch_taken & ~mem_stall;
    end

`ifdef FREEZE_STATS_EN
    logic [STAT_W-1:0] stat_stall_q, stat_stall_d;
    logic [STAT_W-1:0] stat_hazard_q, stat_hazard_d;
    logic [STAT_W-1:0] stat_flush_q, stat_flush_d;

    // Saturating event counters
    always_comb begin
        stat_stall_d  = stat_stall_q;
        stat_hazard_d = stat_hazard_q;
        stat_flush_d  = stat_flush_q;
        if (bus.freeze_pipe && (stat_stall_q != '1)) stat_stall_d  = stat_stall_q + STAT_W'(1);
        if (bus.bubble_id   && (stat_hazard_q != '1)) stat_hazard_d = stat_hazard_q + STAT_W'(1);
        if (bus.flush       && (stat_flush_q != '1)) stat_flush_d  = stat_flush_q + STAT_W'(1);
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_q  <= '0;
            stat_hazard_q <= '0;
            stat_flush_q  <= '0;
        end else begin
            stat_stall_q  <= stat_stall_d;
            stat_hazard_q <= stat_hazard_d;
            stat_flush_q  <= stat_flush_d;
        end
    end

    assign bus.stat_stall  = stat_stall_q;
    assign bus.stat_hazard = stat_hazard_q;
    assign bus.stat_flush  = stat_flush_q;
`else
    assign bus.stat_stall  = '0;
    assign bus.stat_hazard = '0;
    assign bus.stat_flush  = '0;
`endif

endmodule

// File: tb/tb_pipeline_freeze_ctrl.sv
// tb/tb_pipeline_freeze_ctrl.sv - directed self-checking bench for pipeline_freeze_ctrl
module tb_pipeline_freeze_ctrl;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    pipeline_freeze_ctrl_if #(.STAT_W(32)) bus ();

    pipeline_freeze_ctrl #(
        .MEM_WAIT (4),
        .CNT_W    (4),
        .STAT_W   (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Output vector order: freeze_if, bubble_id, freeze_pipe, flush, sram_busy
    logic [4:0] outs;
    assign outs = {bus.freeze_if, bus.bubble_id, bus.freeze_pipe, bus.flush, bus.sram_busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout obs=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic hz, input logic br, input logic rd, input logic wr);
        bus.hazard       = hz;
        bus.branch_taken = br;
        bus.mem_r_en     = rd;
        bus.mem_w_en     = wr;
        #1;
    endtask

`ifdef FREEZE_STATS_EN
    localparam logic [31:0] EXP_STALL8 = 32'd8;
    localparam logic [31:0] EXP_ONE    = 32'd1;
`else
    localparam logic [31:0] EXP_STALL8 = 32'd0;
    localparam logic [31:0] EXP_ONE    = 32'd0;
`endif

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;

        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("idle_%0d", i), 32'(outs), 32'h00);
            tick();
        end

        // Single load, MEM_WAIT=4: IDLE stall, three WAIT stalls, DONE advances
        drive(0, 0, 1, 0);
        chk("ld_idle", 32'(outs), 32'b10100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ld_wait_%0d", i), 32'(outs), 32'b10101);
        end
        tick();
        chk("ld_done", 32'(outs), 32'b00001);
        tick();
        drive(0, 0, 0, 0);
        chk("ld_after", 32'(outs), 32'b00000);

        // Hazard alone: one-cycle hold plus bubble
        drive(1, 0, 0, 0);
        chk("hazard", 32'(outs), 32'b11000);
        tick();
        drive(0, 0, 0, 0);
        chk("hazard_off", 32'(outs), 32'b00000);

        // Branch overrides hazard
        drive(1, 1, 0, 0);
        chk("br_hz", 32'(outs), 32'b00010);
        tick();
        drive(0, 0, 0, 0);

        // Branch raised during second stall cycle of a store: flush deferred to DONE
        drive(0, 0, 0, 1);
        chk("st_idle", 32'(outs), 32'b10100);
        tick();
        drive(0, 1, 0, 1);
        chk("st_br_w0", 32'(outs), 32'b10101);
        tick();
        chk("st_br_w1", 32'(outs), 32'b10101);
        tick();
        chk("st_br_w2", 32'(outs), 32'b10101);
        tick();
        chk("st_br_done", 32'(outs), 32'b00011);
        tick();
        drive(0, 0, 0, 0);
        chk("st_after", 32'(outs), 32'b00000);

        // Hazard + branch + request together in IDLE
        drive(1, 1, 1, 0);
        chk("all_idle", 32'(outs), 32'b10100);
        tick();
        drive(0, 0, 1, 0);
        chk("rst_w_cnt2", 32'(outs), 32'b10101);
        tick();
        chk("rst_w_cnt1", 32'(outs), 32'b10101);
        // Reset in WAIT with cnt=1 aborts the access
        rst = 1'b1;
        drive(0, 0, 0, 0);
        chk("rst_pending", 32'(outs), 32'b10101);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_abort", 32'(outs), 32'b00000);
        chk("stat_stall_rst", bus.stat_stall, 32'd0);
        chk("stat_hazard_rst", bus.stat_hazard, 32'd0);
        chk("stat_flush_rst", bus.stat_flush, 32'd0);

        // Back-to-back loads: second access starts in IDLE right after DONE
        drive(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("b2b_done1", 32'(outs), 32'b00001);
        tick();
        chk("b2b_idle2", 32'(outs), 32'b10100);
        for (int i = 0; i < 4; i++) tick();
        chk("b2b_done2", 32'(outs), 32'b00001);
        tick();
        drive(0, 0, 0, 0);
        chk("b2b_after", 32'(outs), 32'b00000);
        chk("stat_stall_8", bus.stat_stall, EXP_STALL8);

        // One bubble and one flush for the remaining counters
        drive(1, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        chk("stat_hazard_1", bus.stat_hazard, EXP_ONE);
        chk("stat_flush_1", bus.stat_flush, EXP_ONE);
        chk("stat_stall_hold", bus.stat_stall, EXP_STALL8);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
